demux_1to4_stream: RTL and testbench
====================================

# demux_1to4_stream

Stream demultiplexer: one valid/ready input stream routed to one of four output channels chosen by a 2-bit select, with a single registered output stage and per-channel beat counters. It performs the reverse of the 4-to-1 mux, fanning one source out to four sinks instead of selecting one of four. It sits between a single producer and four consumers in the datapath.

## Interface
- WIDTH, 8, data bits per beat
- CNT_W, 16, width of each per-channel beat counter
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  input beat payload
- in_valid  input  1  input beat present
- in_last  input  1  final beat of packet
- in_ready  output  1  block accepts beat this cycle
- sel  input  2  destination channel, 0..3
- out_data  output  WIDTH  payload, shared by all channels
- out_last  output  1  last flag of held beat
- out_valid  output  4  one-hot; bit k = beat offered to channel k
- out_ready  input  4  bit k = channel k accepts
- cnt  output  4*CNT_W  beats delivered; channel k at [k*CNT_W +: CNT_W]

## Operation
- One-entry holding register stores data, last, dest (2 b), full flag.
- Destination selection:
  - dest_next = sel (macro absent).
  - dest_next = lock FSM output (macro present).
- Output drive:
  - out_valid = full ? (4'b0001 << dest) : 4'b0000.
  - At most one out_valid bit is ever high.
- Pop: out_valid[dest] && out_ready[dest]. out_ready bits of non-destination channels are ignored.
- in_ready = !full || out_ready[dest].
- Push: in_valid && in_ready. Loads data, last, dest_next; full=1.
- Simultaneous push+pop: register reloads, full stays 1. Full throughput, one beat/cycle.
- Pop without push: full=0. Payload stays stale; no requirement on its value.
- Counters:
  - cnt[k] increments on each pop on channel k.
  - Wraps from 2^CNT_W-1 to 0. No saturation.
- No beat is dropped, duplicated or reordered.
- Stalled output (out_ready[dest]=0 while full): data/last/dest held stable, in_ready=0.

## Timing
- Latency: beat accepted at edge N appears on out_* in cycle after edge N (1 cycle).
- in_valid/in_data/sel -> out_*: registered only.
- Combinational paths:
  - out_ready -> in_ready (by design).
  - in_valid -> in_ready: none.
- Reset values, held while rst=1:
  - full=0, out_valid=0, out_data=0, out_last=0, every cnt lane 0, FSM IDLE.
  - in_ready=1 in the cycle after reset deasserts.
- Reset mid-packet or with a beat held: beat discarded, lock released, counters cleared.

## Configuration
- DEMUX_PKT_LOCK_EN defined: packet lock FSM compiled in.
  - IDLE: dest_next = sel. Push with in_last=0 -> LOCKED, lock_ch = sel.
  - IDLE: push with in_last=1 (single-beat packet) stays IDLE.
  - LOCKED: dest_next = lock_ch; sel ignored. Push with in_last=1 -> IDLE.
  - No pushes: state holds.
- DEMUX_PKT_LOCK_EN undefined: no FSM.
  - sel sampled on every push.
  - in_last carried to out_last only; it has no routing effect.

## Structure
- Shared package/header holds:
  - N_CH=4 and SEL_W=2.
  - FSM state encodings: IDLE=1'b0, LOCKED=1'b1.
  - Helper mapping channel index to one-hot mask.
- Natural sub-module: stream_hold_reg, a one-entry valid/ready register parameterised on payload width. It is instantiated once with payload {dest, last, data}.
- Counters and lock FSM stay in the top module.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, all cnt=0. in_ready=1 after deassert.
- Routing: sel=2, in_data=8'hA5, in_valid=1, out_ready=4'hF.
  - Next cycle out_valid=4'b0100, out_data=8'hA5.
  - After pop, cnt lane 2 = 1.
- Backpressure: out_ready=0 for 5 cycles with a beat held.
  - out_* stable, in_ready=0.
  - Release -> exactly one pop, no loss.
- Back-to-back: 8 beats with sel cycling 0,1,2,3 and out_ready=4'hF.
  - One beat per cycle, in order, correct one-hot each.
  - Every cnt lane = 2.
- Packet lock (macro defined): 3-beat packet, sel 1 on first beat, then 3, then 0.
  - All three beats go to channel 1.
  - Next packet with sel=3 goes to channel 3.
  - Macro undefined: beats go to 1, 3, 0.
- Wrap: CNT_W=4, deliver 17 beats to channel 0 -> cnt lane 0 = 1. Reset mid-packet -> next beat routed by sel.

Source files
------------

// File: rtl/demux_1to4_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_1to4_stream_pkg
// Description : Shared constants, lock FSM state encoding and channel-mask
//               helper for the 1-to-4 stream demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_1to4_stream_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Channel index to one-hot channel mask
  function automatic logic [N_CH-1:0] ch_onehot(input logic [SEL_W-1:0] ch);
    logic [N_CH-1:0] mask;
    mask     = '0;
    mask[ch] = 1'b1;
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_hold_reg.sv
`default_nettype none
// ============================================================================
// Module      : stream_hold_reg
// Description : One-entry valid/ready holding register. Accepts a new beat
//               whenever it is empty or its current beat leaves in the same
//               cycle, giving one beat per cycle with a registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_payload,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_payload,
  output logic         out_valid,
  input  logic         out_ready
);

  logic         full;
  logic [W-1:0] payload;
  logic         push;

  // Room exists when empty, or when the held beat drains this cycle
  assign in_ready = !full || out_ready;
  assign push     = in_valid && in_ready;

  // Load on push; drop the full flag on a pop without a refill (payload left stale)
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 1'b0;
      payload <= '0;
    end else if (push) begin
      full    <= 1'b1;
      payload <= in_payload;
    end else if (out_ready) begin
      full    <= 1'b0;
    end
  end

  assign out_payload = payload;
  assign out_valid   = full;

endmodule
`default_nettype wire

// File: rtl/demux_1to4_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux_1to4_stream
// Description : Routes one valid/ready stream to one of four output channels
//               through a single registered stage, with a wrapping beat
//               counter per channel. Defining DEMUX_PKT_LOCK_EN compiles in a
//               packet lock that keeps every beat of a packet on the channel
//               selected by its first beat.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1to4_stream
  import demux_1to4_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [N_CH*CNT_W-1:0] cnt
);

  localparam int PAY_W = SEL_W + 1 + WIDTH;

  logic [SEL_W-1:0] dest_next;
  logic [SEL_W-1:0] dest;
  logic [PAY_W-1:0] hold_payload;
  logic             hold_valid;
  logic             dest_ready;
  logic             push;
  logic             pop;

  assign push       = in_valid && in_ready;
  assign dest_ready = out_ready[dest];
  assign pop        = hold_valid && dest_ready;

  stream_hold_reg #(
    .W (PAY_W)
  ) u_hold (
    .clk         (clk),
    .rst         (rst),
    .in_payload  ({dest_next, in_last, in_data}),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_payload (hold_payload),
    .out_valid   (hold_valid),
    .out_ready   (dest_ready)
  );

  assign dest      = hold_payload[PAY_W-1 -: SEL_W];
  assign out_last  = hold_payload[WIDTH];
  assign out_data  = hold_payload[WIDTH-1:0];
  assign out_valid = hold_valid ? ch_onehot(dest) : '0;

`ifdef DEMUX_PKT_LOCK_EN
  lock_state_t      state;
  logic [SEL_W-1:0] lock_ch;

  assign dest_next = (state == LOCKED) ? lock_ch : sel;

  // Packet lock: first beat of a multi-beat packet pins the channel until its last beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lock_ch <= '0;
    end else if (push) begin
      case (state)
        IDLE: begin
          if (!in_last) begin
            state   <= LOCKED;
            lock_ch <= sel;
          end
        end
        LOCKED: begin
          if (in_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign dest_next = sel;
`endif

  logic [CNT_W-1:0] cnt_q [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_cnt
    // Count beats delivered on channel k; wraps naturally at 2^CNT_W
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q[k] <= '0;
      end else if (pop && (dest == SEL_W'(k))) begin
        cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
    assign cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_demux_1to4_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1to4_stream
// Description : Scoreboard bench for demux_1to4_stream. Stimulus pushes the
//               expected beat into a queue on acceptance; a monitor pops and
//               compares on every delivered beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1to4_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
`ifdef DEMUX_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  typedef struct {
    logic [1:0]       ch;
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [1:0]         sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*CNT_W-1:0] cnt;

  beat_t            q[$];
  logic [CNT_W-1:0] exp_cnt [4];
  int               checks = 0;
  int               errs   = 0;
  int               cyc    = 0;

  demux_1to4_stream #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt       (cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every delivered beat must match the oldest expected beat
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid !== 4'b0000) begin
      chk("onehot", 32'($countones(out_valid)), 32'd1);
      if ((out_valid & out_ready) !== 4'b0000) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", {28'd0, out_valid}, 32'd0);
        end else begin
          beat_t b;
          b = q.pop_front();
          chk("out_valid", {28'd0, out_valid}, {28'd0, 4'b0001 << b.ch});
          chk("out_data", {24'd0, out_data}, {24'd0, b.data});
          chk("out_last", {31'd0, out_last}, {31'd0, b.last});
          exp_cnt[b.ch] = exp_cnt[b.ch] + 1'b1;
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge
  task automatic send(input logic [1:0] s, input logic [WIDTH-1:0] d,
                      input logic l, input logic [1:0] exp_ch);
    bit ok, r;
    ok = 1'b0;
    sel = s; in_data = d; in_last = l; in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      if (r) begin
        beat_t b;
        b.ch = exp_ch; b.data = d; b.last = l;
        q.push_back(b);
        ok = 1'b1;
      end
    end
    #1;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 30 && q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic check_cnts(input string name);
    for (int k = 0; k < 4; k++)
      chk(name, {28'd0, cnt[k*CNT_W +: CNT_W]}, {28'd0, exp_cnt[k]});
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    q.delete();
    for (int k = 0; k < 4; k++) exp_cnt[k] = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) exp_cnt[k] = '0;
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b0; sel = 2'd1; out_ready = 4'hF;

    // Reset held two cycles with in_valid high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_cnt", {16'd0, cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid2", {28'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Routing to channel 2
    send(2'd2, 8'hA5, 1'b1, 2'd2);
    in_valid = 1'b0;
    @(negedge clk);
    chk("route_valid", {28'd0, out_valid}, 32'h4);
    chk("route_data", {24'd0, out_data}, 32'hA5);
    @(posedge clk); #1;
    drain();
    chk("route_cnt2", {28'd0, cnt[2*CNT_W +: CNT_W]}, 32'd1);

    // Backpressure: beat held for five cycles
    out_ready = 4'h0;
    send(2'd1, 8'h3C, 1'b1, 2'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {28'd0, out_valid}, 32'h2);
      chk("bp_data", {24'd0, out_data}, 32'h3C);
      chk("bp_last", {31'd0, out_last}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 4'hF;
    drain();
    @(posedge clk); #1;
    chk("bp_cnt1", {28'd0, cnt[1*CNT_W +: CNT_W]}, 32'd1);
    check_cnts("bp_cnt");

    // Back-to-back, sel cycling, one beat per cycle
    do_reset();
    begin
      int t0;
      t0 = cyc;
      for (int i = 0; i < 8; i++)
        send(2'(i), 8'(8'h10 + i), (i == 7), 2'(i));
      chk("b2b_cycles", 32'(cyc - t0), 32'd8);
    end
    in_valid = 1'b0;
    drain();
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++)
      chk("b2b_cnt", {28'd0, cnt[k*CNT_W +: CNT_W]}, 32'd2);

    // Packet: sel 1, 3, 0 over three beats, then a single-beat packet on 3
    send(2'd1, 8'hB0, 1'b0, 2'd1);
    send(2'd3, 8'hB1, 1'b0, LOCK ? 2'd1 : 2'd3);
    send(2'd0, 8'hB2, 1'b1, LOCK ? 2'd1 : 2'd0);
    send(2'd3, 8'hB3, 1'b1, 2'd3);
    in_valid = 1'b0;
    drain();
    @(posedge clk); #1;
    check_cnts("pkt_cnt");

    // Counter wrap: 17 beats on channel 0 with a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++)
      send(2'd0, 8'(i), 1'b1, 2'd0);
    in_valid = 1'b0;
    drain();
    @(posedge clk); #1;
    chk("wrap_cnt0", {28'd0, cnt[0 +: CNT_W]}, 32'd1);

    // Reset with a first-of-packet beat held: beat dropped, lock released
    out_ready = 4'h0;
    send(2'd2, 8'h77, 1'b0, 2'd2);
    in_valid = 1'b0;
    @(posedge clk); #1;
    do_reset();
    chk("midrst_cnt", {16'd0, cnt}, 32'd0);
    out_ready = 4'hF;
    send(2'd3, 8'h88, 1'b1, 2'd3);
    in_valid = 1'b0;
    drain();
    @(posedge clk); #1;
    chk("midrst_cnt3", {28'd0, cnt[3*CNT_W +: CNT_W]}, 32'd1);
    chk("midrst_cnt2", {28'd0, cnt[2*CNT_W +: CNT_W]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

  // Hard stop guard
  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
